// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage controller for the 16-bit five-stage pipeline. It sits
// between the EX/MEM and MEM/WB registers. A load or store in the EX/MEM slot
// becomes a registered req/ack transaction on the data-memory port. While the
// access is outstanding, the upstream pipeline is stalled. Load data goes to
// MEM/WB together with a one-cycle valid strobe.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN):
//   When defined, an access that stays BUSY for TIMEOUT cycles without an
//   ack is aborted. The sticky mem_err flag is raised. An aborted load
//   returns 16'hDEAD with a valid strobe. When undefined, BUSY waits
//   indefinitely and mem_err is tied low.
//
// Parameters:
//   DATA_W   data and address width
//   TIMEOUT  BUSY cycles without ack before abort (MEM_TIMEOUT_EN only)
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   valid_in         EX/MEM slot holds a live instruction
//   mem_read_in      instruction is a load
//   mem_write_in     instruction is a store (wins over a read)
//   addr_in          effective address
//   wdata_in         store data
//   dmem_req         registered memory request
//   dmem_we          registered write enable (1 = write)
//   dmem_addr        latched address
//   dmem_wdata       latched store data
//   dmem_ack         memory completes the request this cycle
//   dmem_rdata       read data, valid with dmem_ack on a read
//   stall            combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   rdata_out        captured load data for MEM/WB
//   rdata_valid      one-cycle strobe, rdata_out was updated
//   mem_err          sticky timeout error flag
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              mem_err
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic state;
    logic start;
    logic busy;
    logic abort;

    assign start = valid_in & (mem_read_in | mem_write_in);
    assign busy  = (state == ST_BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // The counter holds (BUSY cycles elapsed - 1). The abort therefore fires
    // on the edge that ends the TIMEOUT-th un-acked BUSY cycle.
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(16'hDEAD);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_flag;

    // An ack in the same cycle takes priority over the timeout.
    assign abort   = busy & ~dmem_ack & (wait_cnt == CNT_LAST);
    assign mem_err = err_flag;
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Upstream may advance in the ack cycle and in the abort cycle.
    assign stall = (~busy & start) | (busy & ~dmem_ack & ~abort);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt    <= '0;
            err_flag    <= 1'b0;
`endif
        end else begin
            rdata_valid <= 1'b0;
            if (!busy) begin
                // A stray ack while IDLE is deliberately ignored.
                if (start) begin
                    state      <= ST_BUSY;
                    dmem_req   <= 1'b1;
                    // Read+write together is treated as a write.
                    dmem_we    <= mem_write_in;
                    dmem_addr  <= addr_in;
                    dmem_wdata <= wdata_in;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end
            end else begin
                // Request fields stay frozen while BUSY. Upstream inputs
                // are ignored until the access completes.
                if (dmem_ack) begin
                    state    <= ST_IDLE;
                    dmem_req <= 1'b0;
                    if (!dmem_we) begin
                        rdata_out   <= dmem_rdata;
                        rdata_valid <= 1'b1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (abort) begin
                    state    <= ST_IDLE;
                    dmem_req <= 1'b0;
                    err_flag <= 1'b1;
                    if (!dmem_we) begin
                        rdata_out   <= ABORT_DATA;
                        rdata_valid <= 1'b1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
`endif
            end
        end
    end

endmodule
